sram_burst_ctrl: RTL and testbench

- Parametrised asynchronous-SRAM controller; successor to the single-access MAX II SRAM block.
- Adds configurable address and data width, programmable read/write wait states, and incrementing bursts of 1..2^LEN_W beats.
- Sits between the user logic and the external SRAM pins (ram_addr, ram_dq, ram_we_, ram_oe_, ram_cs1_, ram_cs2).
- Uses the same ena/write/busy request handshake as before.

---
 rtl/sram_pkg.sv | 18 +
 rtl/sram_dq_io.sv | 29 ++
 rtl/sram_burst_ctrl.sv | 134 +++++++++++++
 tb/tb_sram_burst_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types for the async-SRAM burst controller: access FSM encoding and
// the helper that sizes the wait-state down-counter from the read/write waits.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    END
  } state_t;

  function automatic int calc_wait_w(input int rd_wait, input int wr_wait);
    int max_wait;
    max_wait = (rd_wait > wr_wait) ? rd_wait : wr_wait;
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/sram_dq_io.sv
// Bidirectional SRAM data pin: registered drive enable and read capture register.
// Drive takes effect one cycle after drive_d; capture lands on the edge where cap_en is high.
module sram_dq_io #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              drive_d,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              cap_en,
  output logic [DATA_W-1:0] rd_dat,
  output logic              drive_q,
  inout  wire  [DATA_W-1:0] ram_dq
);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      drive_q <= 1'b0;
      rd_dat  <= '0;
    end else begin
      drive_q <= drive_d;
      if (cap_en) rd_dat <= ram_dq;
    end
  end

  // Write data follows data_in directly; the user holds it until wr_ack.
  assign ram_dq = drive_q ? wr_dat : {DATA_W{1'bz}};

endmodule

// File: rtl/sram_burst_ctrl.sv
// Async-SRAM burst controller: SETUP/ACCESS/END per beat, beat period = WAIT+2 cycles.
// No queuing: ena is only taken while busy=0; write data advances on each wr_ack pulse.
module sram_burst_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 8,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1,
  parameter int LEN_W   = 4
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              ena,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] data_in,
  output logic              wr_ack,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_dq,
  output logic              ram_we_,
  output logic              ram_oe_,
  output logic              ram_cs1_,
  output logic              ram_cs2
);

  localparam int WAIT_W = calc_wait_w(RD_WAIT, WR_WAIT);
  localparam logic [WAIT_W-1:0] RD_LD = WAIT_W'(RD_WAIT - 1);
  localparam logic [WAIT_W-1:0] WR_LD = WAIT_W'(WR_WAIT - 1);

  state_t              state_q, state_d;
  logic                wr_q, wr_eff, accept;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cs_d, oe_d, we_d, drive_d, wr_ack_d, cap_en;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ena) begin
          accept  = 1'b1;
          state_d = SETUP;
          addr_d  = addr;
          beat_d  = len;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        wait_d  = wr_q ? WR_LD : RD_LD;
      end
      ACCESS: begin
        if (wait_q == '0) state_d = END;
        else              wait_d  = wait_q - WAIT_W'(1);
      end
      END: begin
        if (beat_q == '0) begin
          state_d = IDLE;
        end else begin
          state_d = SETUP;
          beat_d  = beat_q - LEN_W'(1);
          addr_d  = addr_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Pin controls are registered from the next state so the SRAM sees glitch-free strobes.
    wr_eff   = accept ? write : wr_q;
    cs_d     = (state_d != IDLE);
    oe_d     = !(cs_d && !wr_eff);
    we_d     = !((state_d == ACCESS) && wr_eff);
    drive_d  = cs_d && wr_eff;
    wr_ack_d = (state_d == END) && wr_eff;
    cap_en   = (state_q == END) && !wr_q;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      beat_q   <= '0;
      wait_q   <= '0;
      addr_q   <= '0;
      busy     <= 1'b0;
      rd_valid <= 1'b0;
      wr_ack   <= 1'b0;
      ram_we_  <= 1'b1;
      ram_oe_  <= 1'b1;
      ram_cs1_ <= 1'b1;
      ram_cs2  <= 1'b0;
    end else begin
      state_q  <= state_d;
      if (accept) wr_q <= write;
      beat_q   <= beat_d;
      wait_q   <= wait_d;
      addr_q   <= addr_d;
      busy     <= cs_d;
      rd_valid <= cap_en;
      wr_ack   <= wr_ack_d;
      ram_we_  <= we_d;
      ram_oe_  <= oe_d;
      ram_cs1_ <= !cs_d;
      ram_cs2  <= cs_d;
    end
  end

  assign ram_addr = addr_q;

  logic dq_drive;

  sram_dq_io #(
    .DATA_W (DATA_W)
  ) u_dq_io (
    .clk     (clk),
    .rst_    (rst_),
    .drive_d (drive_d),
    .wr_dat  (data_in),
    .cap_en  (cap_en),
    .rd_dat  (data_out),
    .drive_q (dq_drive),
    .ram_dq  (ram_dq)
  );

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed bench for sram_burst_ctrl: default instance (A) and RD_WAIT=3/WR_WAIT=2 instance (B),
// each against a behavioural async-SRAM model.
module tb_sram_burst_ctrl;

  logic        clk, rst_;
  logic        ena[2], write[2];
  logic [16:0] addr[2];
  logic [3:0]  len[2];
  logic [7:0]  data_in[2];
  logic        wr_ack[2], rd_valid[2], busy[2], we_[2], oe_[2], cs1_[2], cs2[2];
  logic [7:0]  data_out[2];
  logic [16:0] ram_addr_a;
  logic [7:0]  ram_addr_b;
  wire  [7:0]  ram_dq_a, ram_dq_b;
  logic [16:0] raddr[2];
  logic        drv[2];

  logic [7:0]  mem_a [0:131071];
  logic [7:0]  mem_b [0:255];
  logic [7:0]  wdat  [0:3];

  int n_vec, n_err;
  int busy_cyc[2], rdv_cnt[2], ack_cnt[2], we_low[2], we_bad[2], we_run[2];
  int excl_viol[2], drv_viol[2], addr_cnt[2], hit200;
  logic [7:0]  rd_log[2][0:31];
  logic [16:0] addr_log[2][0:31];
  logic        prev_cs[2];
  logic [16:0] prev_addr[2];
  logic        mon_cs;
  int          wr_wait_of[2];

  sram_burst_ctrl u_dut_a (
    .clk(clk), .rst_(rst_), .ena(ena[0]), .write(write[0]), .addr(addr[0]), .len(len[0]),
    .data_in(data_in[0]), .wr_ack(wr_ack[0]), .data_out(data_out[0]), .rd_valid(rd_valid[0]),
    .busy(busy[0]), .ram_addr(ram_addr_a), .ram_dq(ram_dq_a), .ram_we_(we_[0]), .ram_oe_(oe_[0]),
    .ram_cs1_(cs1_[0]), .ram_cs2(cs2[0])
  );

  sram_burst_ctrl #(.ADDR_W(8), .DATA_W(8), .RD_WAIT(3), .WR_WAIT(2), .LEN_W(4)) u_dut_b (
    .clk(clk), .rst_(rst_), .ena(ena[1]), .write(write[1]), .addr(addr[1][7:0]), .len(len[1]),
    .data_in(data_in[1]), .wr_ack(wr_ack[1]), .data_out(data_out[1]), .rd_valid(rd_valid[1]),
    .busy(busy[1]), .ram_addr(ram_addr_b), .ram_dq(ram_dq_b), .ram_we_(we_[1]), .ram_oe_(oe_[1]),
    .ram_cs1_(cs1_[1]), .ram_cs2(cs2[1])
  );

  assign raddr[0] = ram_addr_a;
  assign raddr[1] = {9'd0, ram_addr_b};
  assign drv[0]   = u_dut_a.u_dq_io.drive_q;
  assign drv[1]   = u_dut_b.u_dq_io.drive_q;

  // SRAM models: drive on chip-select + oe_, store while we_ is low.
  assign ram_dq_a = (!oe_[0] && !cs1_[0] && cs2[0]) ? mem_a[ram_addr_a] : 8'bz;
  assign ram_dq_b = (!oe_[1] && !cs1_[1] && cs2[1]) ? mem_b[ram_addr_b] : 8'bz;

  always @(negedge clk) begin
    if (!we_[0] && !cs1_[0] && cs2[0]) mem_a[ram_addr_a] <= ram_dq_a;
    if (!we_[1] && !cs1_[1] && cs2[1]) mem_b[ram_addr_b] <= ram_dq_b;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      mon_cs = !cs1_[i] && cs2[i];
      if (busy[i]) busy_cyc[i]++;
      if (wr_ack[i]) ack_cnt[i]++;
      if (rd_valid[i]) begin
        if (rdv_cnt[i] < 32) rd_log[i][rdv_cnt[i]] = data_out[i];
        rdv_cnt[i]++;
      end
      if (mon_cs && (!prev_cs[i] || raddr[i] != prev_addr[i])) begin
        if (addr_cnt[i] < 32) addr_log[i][addr_cnt[i]] = raddr[i];
        addr_cnt[i]++;
      end
      prev_cs[i]   = mon_cs;
      prev_addr[i] = raddr[i];
      if (!we_[i]) begin
        we_low[i]++;
        we_run[i]++;
      end else if (we_run[i] != 0) begin
        if (we_run[i] != wr_wait_of[i]) we_bad[i]++;
        we_run[i] = 0;
      end
      if (!we_[i] && !oe_[i]) excl_viol[i]++;
      if (drv[i] && !oe_[i]) drv_viol[i]++;
      if (i == 0 && mon_cs && raddr[i] == 17'd200) hit200++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear(input int i);
    busy_cyc[i] = 0; rdv_cnt[i] = 0; ack_cnt[i] = 0; we_low[i] = 0;
    we_bad[i] = 0; we_run[i] = 0; addr_cnt[i] = 0; prev_cs[i] = 1'b0;
  endtask

  task automatic start(input int i, input logic w, input logic [16:0] a, input logic [3:0] l,
                       input logic [7:0] d);
    @(negedge clk);
    chk("idle_before_req", busy[i], 1'b0);
    ena[i] = 1'b1; write[i] = w; addr[i] = a; len[i] = l; data_in[i] = d;
    @(negedge clk);
    ena[i] = 1'b0;
    chk("busy_rise", busy[i], 1'b1);
  endtask

  task automatic wait_idle(input int i, input int budget);
    int n;
    n = 0;
    while (busy[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy[i]) chk("busy_timeout", busy[i], 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_read(input int i, input logic [16:0] a, input logic [3:0] l, input int budget);
    start(i, 1'b0, a, l, 8'h00);
    wait_idle(i, budget);
  endtask

  task automatic do_write(input int i, input logic [16:0] a, input logic [3:0] l, input int budget);
    int n;
    start(i, 1'b1, a, l, wdat[0]);
    for (int k = 1; k <= int'(l); k++) begin
      n = 0;
      while (!wr_ack[i] && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (!wr_ack[i]) chk("ack_timeout", wr_ack[i], 1'b1);
      @(posedge clk);
      #1 data_in[i] = wdat[k];
    end
    wait_idle(i, budget);
  endtask

  initial begin
    int n;
    n_vec = 0; n_err = 0; hit200 = 0;
    wr_wait_of[0] = 1; wr_wait_of[1] = 2;
    for (int i = 0; i < 2; i++) begin
      ena[i] = 1'b0; write[i] = 1'b0; addr[i] = '0; len[i] = '0; data_in[i] = '0;
      excl_viol[i] = 0; drv_viol[i] = 0;
      clear(i);
    end
    rst_ = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_busy", busy[0], 1'b0);
    chk("rst_rd_valid", rd_valid[0], 1'b0);
    chk("rst_wr_ack", wr_ack[0], 1'b0);
    chk("rst_data_out", data_out[0], 8'h00);
    chk("rst_ram_addr", ram_addr_a, 17'h0);
    chk("rst_we", we_[0], 1'b1);
    chk("rst_oe", oe_[0], 1'b1);
    chk("rst_cs1", cs1_[0], 1'b1);
    chk("rst_cs2", cs2[0], 1'b0);
    chk("rst_dq_drive", drv[0], 1'b0);
    rst_ = 1'b1;

    // Single read, RD_WAIT=1.
    mem_a[100] = 8'hA5;
    clear(0);
    do_read(0, 17'd100, 4'd0, 20);
    chk("rd1_busy_cycles", busy_cyc[0], 3);
    chk("rd1_rd_valid_cnt", rdv_cnt[0], 1);
    chk("rd1_data", rd_log[0][0], 8'hA5);
    chk("rd1_data_held", data_out[0], 8'hA5);
    chk("rd1_addr", addr_log[0][0], 17'd100);

    // Four-beat write burst, data advanced on wr_ack.
    wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33; wdat[3] = 8'h44;
    clear(0);
    do_write(0, 17'h10, 4'd3, 40);
    chk("wr4_acks", ack_cnt[0], 4);
    chk("wr4_mem10", mem_a[17'h10], 8'h11);
    chk("wr4_mem11", mem_a[17'h11], 8'h22);
    chk("wr4_mem12", mem_a[17'h12], 8'h33);
    chk("wr4_mem13", mem_a[17'h13], 8'h44);
    chk("wr4_we_runs_bad", we_bad[0], 0);
    chk("wr4_we_low_total", we_low[0], 4);
    chk("wr4_busy_cycles", busy_cyc[0], 12);

    // Address wrap at the top of the array.
    mem_a[17'h1FFFF] = 8'h5A; mem_a[0] = 8'hC3;
    clear(0);
    do_read(0, 17'h1FFFF, 4'd1, 30);
    chk("wrap_addr_cnt", addr_cnt[0], 2);
    chk("wrap_addr0", addr_log[0][0], 17'h1FFFF);
    chk("wrap_addr1", addr_log[0][1], 17'h00000);
    chk("wrap_rdv_cnt", rdv_cnt[0], 2);
    chk("wrap_dat0", rd_log[0][0], 8'h5A);
    chk("wrap_dat1", rd_log[0][1], 8'hC3);

    // ena while busy must be dropped.
    mem_a[17'h20] = 8'h6B;
    clear(0);
    hit200 = 0;
    start(0, 1'b0, 17'h20, 4'd0, 8'h00);
    @(negedge clk);
    ena[0] = 1'b1; addr[0] = 17'd200;
    @(negedge clk);
    ena[0] = 1'b0;
    wait_idle(0, 20);
    chk("busy_ena_no_200", hit200, 0);
    chk("busy_ena_busy_cycles", busy_cyc[0], 3);
    chk("busy_ena_rdv_cnt", rdv_cnt[0], 1);
    chk("busy_ena_data", data_out[0], 8'h6B);

    // Asynchronous reset in the middle of a write beat.
    start(0, 1'b1, 17'h30, 4'd3, 8'hEE);
    n = 0;
    while (we_[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_wr_we_low", we_[0], 1'b0);
    rst_ = 1'b0;
    #1;
    chk("arst_we", we_[0], 1'b1);
    chk("arst_cs1", cs1_[0], 1'b1);
    chk("arst_cs2", cs2[0], 1'b0);
    chk("arst_dq_drive", drv[0], 1'b0);
    chk("arst_busy", busy[0], 1'b0);
    chk("arst_wr_ack", wr_ack[0], 1'b0);
    @(negedge clk);
    rst_ = 1'b1;
    mem_a[5] = 8'h77;
    clear(0);
    do_read(0, 17'd5, 4'd0, 20);
    chk("post_rst_rdv_cnt", rdv_cnt[0], 1);
    chk("post_rst_data", data_out[0], 8'h77);
    chk("post_rst_busy_cycles", busy_cyc[0], 3);

    // Instance B: RD_WAIT=3, WR_WAIT=2, 8-bit address.
    mem_b[8] = 8'h3C;
    clear(1);
    do_read(1, 17'd8, 4'd0, 30);
    chk("b_rd_busy_cycles", busy_cyc[1], 5);
    chk("b_rd_data", data_out[1], 8'h3C);

    wdat[0] = 8'hA1; wdat[1] = 8'hB2; wdat[2] = 8'h00; wdat[3] = 8'h00;
    clear(1);
    do_write(1, 17'h40, 4'd1, 40);
    chk("b_wr_busy_cycles", busy_cyc[1], 8);
    chk("b_wr_acks", ack_cnt[1], 2);
    chk("b_wr_mem40", mem_b[8'h40], 8'hA1);
    chk("b_wr_mem41", mem_b[8'h41], 8'hB2);
    chk("b_wr_we_runs_bad", we_bad[1], 0);
    chk("b_wr_we_low_total", we_low[1], 4);

    // Maximum burst (len all-ones = 16 beats) wrapping through 0xFF.
    for (int k = 0; k < 16; k++) mem_b[(8'hF8 + k) & 8'hFF] = 8'(k * 3 + 1);
    clear(1);
    do_read(1, 17'hF8, 4'hF, 200);
    chk("b_max_rdv_cnt", rdv_cnt[1], 16);
    chk("b_max_busy_cycles", busy_cyc[1], 80);
    chk("b_max_first", rd_log[1][0], 8'd1);
    chk("b_max_last", rd_log[1][15], 8'd46);
    chk("b_max_wrap_addr", addr_log[1][8], 17'h0);
    chk("b_max_last_addr", addr_log[1][15], 17'h7);

    chk("a_oe_we_excl", excl_viol[0], 0);
    chk("b_oe_we_excl", excl_viol[1], 0);
    chk("a_dq_drive_oe", drv_viol[0], 0);
    chk("b_dq_drive_oe", drv_viol[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
